// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite definitions: bridge state encoding, HTRANS/HSIZE codes
// and a helper that identifies transfer types that start a transfer.
package ahbl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } apb_br_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // IDLE and BUSY carry no transfer; only NONSEQ and SEQ open one.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY) &&
           ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  endfunction

endpackage

// File: rtl/ahbl_apb_strb_gen.sv
// Combinational byte-lane strobe decoder for 32-bit APB writes; reads and
// oversize transfers produce no strobes.
module ahbl_apb_strb_gen
  import ahbl_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  input  logic       hwrite,
  output logic [3:0] strb
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign strb[gi] = hwrite &&
                        ((hsize == HSIZE_WORD) ||
                         ((hsize == HSIZE_HALF) && (LANE[1] == addr_lo[1])) ||
                         ((hsize == HSIZE_BYTE) && (LANE == addr_lo)));
    end
  endgenerate

endmodule

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB4 master bridge, one transfer at a time.
// Optional pstrb output is enabled by defining AHBL_APB_PSTRB_EN.
module ahbl_apb_bridge
  import ahbl_pkg::*;
#(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int W_PADDR = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hready,
  output logic               hready_resp,
  output logic               hresp,
  input  logic [W_ADDR-1:0]  haddr,
  input  logic               hwrite,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hsize,
  input  logic [W_DATA-1:0]  hwdata,
  output logic [W_DATA-1:0]  hrdata,
  output logic [W_PADDR-1:0] paddr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [W_DATA-1:0]  pwdata,
`ifdef AHBL_APB_PSTRB_EN
  output logic [3:0]         pstrb,
`endif
  input  logic [W_DATA-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr
);

  apb_br_state_t      state_reg, state_next;
  logic [W_PADDR-1:0] paddr_reg, paddr_next;
  logic               pwrite_reg, pwrite_next;
  logic [W_DATA-1:0]  pwdata_reg, pwdata_next;
  logic [W_DATA-1:0]  hrdata_reg, hrdata_next;
  logic               hready_resp_reg, hresp_reg, psel_reg, penable_reg;
  logic               sample;

  // Upper address bits select this slave upstream and are not forwarded.
  logic unused_haddr;
  assign unused_haddr = &{1'b0, haddr[W_ADDR-1:W_PADDR]};

`ifdef AHBL_APB_PSTRB_EN
  logic [3:0] pstrb_reg, pstrb_next, strb;

  ahbl_apb_strb_gen u_strb_gen (
    .hsize   (hsize),
    .addr_lo (haddr[1:0]),
    .hwrite  (hwrite),
    .strb    (strb)
  );
`endif

  assign sample = ((state_reg == ST_IDLE) || (state_reg == ST_ERR2)) &&
                  hready && htrans_active(htrans);

  always_comb begin
    state_next  = state_reg;
    paddr_next  = paddr_reg;
    pwrite_next = pwrite_reg;
    pwdata_next = pwdata_reg;
    hrdata_next = hrdata_reg;
`ifdef AHBL_APB_PSTRB_EN
    pstrb_next  = pstrb_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_ERR2: begin
        state_next = ST_IDLE;
        if (sample) begin
          paddr_next  = haddr[W_PADDR-1:0];
          pwrite_next = hwrite;
`ifdef AHBL_APB_PSTRB_EN
          pstrb_next  = strb;
`endif
          if (hsize > HSIZE_WORD) state_next = ST_ERR1;
          else if (hwrite)        state_next = ST_WDATA;
          else                    state_next = ST_SETUP;
        end
      end
      ST_WDATA: begin
        pwdata_next = hwdata;
        state_next  = ST_SETUP;
      end
      ST_SETUP: state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            state_next = ST_ERR1;
          end else begin
            state_next = ST_IDLE;
            if (!pwrite_reg) hrdata_next = prdata;
          end
        end
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered copies decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      paddr_reg       <= '0;
      pwrite_reg      <= 1'b0;
      pwdata_reg      <= '0;
      hrdata_reg      <= '0;
      hready_resp_reg <= 1'b1;
      hresp_reg       <= 1'b0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
`ifdef AHBL_APB_PSTRB_EN
      pstrb_reg       <= 4'b0000;
`endif
    end else begin
      state_reg       <= state_next;
      paddr_reg       <= paddr_next;
      pwrite_reg      <= pwrite_next;
      pwdata_reg      <= pwdata_next;
      hrdata_reg      <= hrdata_next;
      hready_resp_reg <= (state_next == ST_IDLE) || (state_next == ST_ERR2);
      hresp_reg       <= (state_next == ST_ERR1) || (state_next == ST_ERR2);
      psel_reg        <= (state_next == ST_SETUP) || (state_next == ST_ACCESS);
      penable_reg     <= (state_next == ST_ACCESS);
`ifdef AHBL_APB_PSTRB_EN
      pstrb_reg       <= pstrb_next;
`endif
    end
  end

  assign hready_resp = hready_resp_reg;
  assign hresp       = hresp_reg;
  assign hrdata      = hrdata_reg;
  assign paddr       = paddr_reg;
  assign psel        = psel_reg;
  assign penable     = penable_reg;
  assign pwrite      = pwrite_reg;
  assign pwdata      = pwdata_reg;
`ifdef AHBL_APB_PSTRB_EN
  assign pstrb       = pstrb_reg;
`endif

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Scoreboard bench for ahbl_apb_bridge: expected APB accesses are queued at
// the address phase and popped by an APB slave/monitor; AHB responses are checked inline.
module tb_ahbl_apb_bridge;

  logic        clk, rst, hready, hready_resp, hresp, hwrite;
  logic [31:0] haddr, hwdata, hrdata, pwdata, prdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [15:0] paddr;
  logic        psel, penable, pwrite, pready, pslverr;
`ifdef AHBL_APB_PSTRB_EN
  logic [3:0]  pstrb;
`endif

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } apb_exp_t;

  apb_exp_t    sb[$];
  int          tests = 0;
  int          fails = 0;
  int          apb_waits = 0;
  int          wait_cnt = 0;
  logic [31:0] apb_rdata = 32'h0;
  logic        apb_err = 1'b0;
  logic [31:0] model_hrdata = 32'h0;

  ahbl_apb_bridge dut (
    .clk(clk), .rst(rst), .hready(hready), .hready_resp(hready_resp),
    .hresp(hresp), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
    .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata), .paddr(paddr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
`ifdef AHBL_APB_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // APB slave: apb_waits wait states per access
  assign pready  = psel && penable && (wait_cnt == apb_waits);
  assign prdata  = apb_rdata;
  assign pslverr = apb_err && pready;

  always @(posedge clk) begin
    if (psel && penable && !pready) wait_cnt <= wait_cnt + 1;
    else                            wait_cnt <= 0;
  end

  always @(negedge clk) begin
    if (!rst && psel) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL apb_unexpected: psel=%b paddr=%h, required no APB access", psel, paddr);
      end else begin
        if (paddr !== sb[0].addr || pwrite !== sb[0].wr ||
            (sb[0].wr && pwdata !== sb[0].data)) begin
          fails++;
          $display("FAIL apb_access: paddr=%h pwrite=%b pwdata=%h, required paddr=%h pwrite=%b pwdata=%h",
                   paddr, pwrite, pwdata, sb[0].addr, sb[0].wr, sb[0].data);
        end
`ifdef AHBL_APB_PSTRB_EN
        tests++;
        if (pstrb !== sb[0].strb) begin
          fails++;
          $display("FAIL apb_pstrb: pstrb=%b, required %b", pstrb, sb[0].strb);
        end
`endif
        if (penable && pready) void'(sb.pop_front());
      end
    end
  end

  function automatic logic [3:0] exp_strb(input logic wr, input logic [2:0] sz,
                                          input logic [1:0] lo);
    logic [3:0] s;
    case (sz)
      3'd0:    s = 4'b0001 << lo;
      3'd1:    s = lo[1] ? 4'b1100 : 4'b0011;
      3'd2:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return wr ? s : 4'b0000;
  endfunction

  // Drives an address phase in the current cycle; returns in data-phase cycle 1.
  task automatic xfer_addr(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                           input logic [31:0] wd, input int waits,
                           input logic [31:0] rd, input logic err);
    apb_exp_t e;
    apb_waits = waits;
    apb_rdata = rd;
    apb_err   = err;
    haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10; hready = 1'b1;
    if (sz <= 3'd2) begin
      e.wr = wr; e.addr = a[15:0]; e.data = wd; e.strb = exp_strb(wr, sz, a[1:0]);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    htrans = 2'b00;
    hwdata = wd;
  endtask

  // Waits for hready_resp; returns in the completion cycle.
  task automatic xfer_data(input string name, input int exp_len, input logic exp_err,
                           output bit sel_seen);
    int n = 1;
    int err1 = 0;
    sel_seen = 1'b0;
    while (hready_resp !== 1'b1 && n < 64) begin
      if (hresp === 1'b1) err1++;
      if (psel === 1'b1) sel_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n !== exp_len) begin
      fails++;
      $display("FAIL %s_len: data phase %0d cycles, required %0d", name, n, exp_len);
    end
    tests++;
    if (hresp !== exp_err) begin
      fails++;
      $display("FAIL %s_hresp: hresp=%b, required %b", name, hresp, exp_err);
    end
    tests++;
    if (err1 !== (exp_err ? 1 : 0)) begin
      fails++;
      $display("FAIL %s_err1: %0d ERR1 cycles, required %0d", name, err1, exp_err ? 1 : 0);
    end
    tests++;
    if (hrdata !== model_hrdata) begin
      fails++;
      $display("FAIL %s_hrdata: hrdata=%h, required %h", name, hrdata, model_hrdata);
    end
    $display("[TB] %s done: %0d cycles hresp=%b hrdata=%h", name, n, hresp, hrdata);
  endtask

  task automatic idle_cycle();
    htrans = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (hready_resp !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_ahb: hready_resp=%b hresp=%b hrdata=%h, required 1 0 0",
               hready_resp, hresp, hrdata);
    end
    tests++;
    if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0 ||
        paddr !== 16'h0 || pwdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_apb: psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, required all 0",
               psel, penable, pwrite, paddr, pwdata);
    end
`ifdef AHBL_APB_PSTRB_EN
    tests++;
    if (pstrb !== 4'b0) begin
      fails++;
      $display("FAIL reset_pstrb: pstrb=%b, required 0000", pstrb);
    end
`endif
    rst = 1'b0;
    idle_cycle();
  endtask

  task automatic test_read();
    bit s;
    xfer_addr(32'h4000_0010, 1'b0, 3'd2, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    tests++;
    if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 16'h0010) begin
      fails++;
      $display("FAIL read_setup: psel=%b penable=%b paddr=%h, required 1 0 0010", psel, penable, paddr);
    end
    model_hrdata = 32'hDEAD_BEEF;
    xfer_data("read", 3, 1'b0, s);
    idle_cycle();
  endtask

  task automatic test_write_wait();
    bit s;
    xfer_addr(32'h4000_0004, 1'b1, 3'd2, 32'h1234_5678, 2, 32'h0, 1'b0);
    xfer_data("write_wait", 6, 1'b0, s);
    idle_cycle();
  endtask

  task automatic test_strb();
    bit s;
    xfer_addr(32'h4000_0003, 1'b1, 3'd0, 32'hAA00_0000, 0, 32'h0, 1'b0);
    xfer_data("write_byte", 4, 1'b0, s);
    idle_cycle();
    xfer_addr(32'h4000_0002, 1'b1, 3'd1, 32'hBBBB_0000, 1, 32'h0, 1'b0);
    xfer_data("write_half", 5, 1'b0, s);
    idle_cycle();
  endtask

  task automatic test_slverr();
    bit s;
    xfer_addr(32'h4000_0020, 1'b0, 3'd2, 32'h0, 0, 32'h1111_1111, 1'b1);
    xfer_data("slverr", 4, 1'b1, s);
    idle_cycle();
  endtask

  task automatic test_bad_size();
    bit s;
    xfer_addr(32'h4000_0008, 1'b1, 3'd3, 32'h9999_9999, 0, 32'h0, 1'b0);
    tests++;
    if (hresp !== 1'b1 || hready_resp !== 1'b0) begin
      fails++;
      $display("FAIL bad_size_err1: hresp=%b hready_resp=%b, required 1 0", hresp, hready_resp);
    end
    xfer_data("bad_size", 2, 1'b1, s);
    tests++;
    if (s !== 1'b0) begin
      fails++;
      $display("FAIL bad_size_psel: psel seen=%b, required 0", s);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    bit s;
    xfer_addr(32'h4000_0030, 1'b0, 3'd2, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
    model_hrdata = 32'hCAFE_F00D;
    xfer_data("b2b_read", 3, 1'b0, s);
    xfer_addr(32'h4000_0034, 1'b1, 3'd2, 32'h5555_AAAA, 0, 32'h0, 1'b0);
    xfer_data("b2b_write", 4, 1'b0, s);
    xfer_addr(32'h4000_0038, 1'b0, 3'd7, 32'h0, 0, 32'h0, 1'b0);
    xfer_data("b2b_bad", 2, 1'b1, s);
    xfer_addr(32'h4000_003C, 1'b0, 3'd2, 32'h0, 0, 32'h0BAD_CAFE, 1'b0);
    model_hrdata = 32'h0BAD_CAFE;
    xfer_data("b2b_after_err", 3, 1'b0, s);
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    bit s;
    xfer_addr(32'h4000_0040, 1'b0, 3'd2, 32'h0, 5, 32'h7777_7777, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      fails++;
      $display("FAIL mid_access: psel=%b penable=%b, required 1 1", psel, penable);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    model_hrdata = 32'h0;
    tests++;
    if (psel !== 1'b0 || penable !== 1'b0 || hresp !== 1'b0 || hready_resp !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: psel=%b penable=%b hresp=%b hready_resp=%b, required 0 0 0 1",
               psel, penable, hresp, hready_resp);
    end
    idle_cycle();
    xfer_addr(32'h4000_0044, 1'b0, 3'd2, 32'h0, 0, 32'h2468_ACE0, 1'b0);
    model_hrdata = 32'h2468_ACE0;
    xfer_data("post_reset_read", 3, 1'b0, s);
    idle_cycle();
  endtask

  initial begin
    rst = 1'b1; hready = 1'b1; htrans = 2'b00; haddr = 32'h0;
    hwrite = 1'b0; hsize = 3'd2; hwdata = 32'h0;
    test_reset();
    test_read();
    test_write_wait();
    test_strb();
    test_slverr();
    test_bad_size();
    test_back_to_back();
    test_reset_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d APB accesses outstanding, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahbl_apb_bridge.md
# ahbl_apb_bridge

AHB-Lite slave to APB4 master bridge that terminates one splitter output port of the AHB-Lite layer and drives a low-speed APB peripheral segment. It accepts one AHB-Lite transfer at a time and converts it into a single APB SETUP/ACCESS sequence. It stretches the AHB data phase with `hready_resp` until the APB slave completes, and maps `pslverr` and illegal sizes onto the two-cycle AHB-Lite ERROR response.

## Interface
- `W_ADDR`, 32: AHB address width.
- `W_DATA`, 32: data width. Only 32 is supported.
- `W_PADDR`, 16: APB address width. `paddr` = `haddr[W_PADDR-1:0]`.
- `clk` in 1: single bus clock for both sides.
- `rst` in 1: reset, synchronous, active-high.
- `hready` in 1: AHB bus ready, the address-phase qualifier.
- `hready_resp` out 1: slave ready; 0 stretches the data phase.
- `hresp` out 1: 1 signals an ERROR response.
- `haddr` in W_ADDR: transfer address.
- `hwrite` in 1: 1 = write.
- `htrans` in 2: transfer type. Only `htrans[1]` (NONSEQ/SEQ) starts a transfer.
- `hsize` in 3: transfer size, 0 = byte, 1 = half, 2 = word.
- `hwdata` in W_DATA: write data, valid in the data phase.
- `hrdata` out W_DATA: registered read data.
- `paddr` out W_PADDR: APB address.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB direction.
- `pwdata` out W_DATA: APB write data.
- `pstrb` out 4: byte strobes. Present only with `AHBL_APB_PSTRB_EN`.
- `prdata` in W_DATA: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.

## Operation
- States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- A transfer is sampled in IDLE or ERR2 when `hready && htrans[1]`. At that point the bridge registers `haddr`, `hwrite` and `hsize`.
- From IDLE or ERR2, the next state is:
  - ERR1 if `hsize > 2`. No APB access is issued.
  - WDATA if the transfer is a write.
  - SETUP if the transfer is a read.
  - IDLE if nothing is sampled.
- WDATA: captures `hwdata` into `pwdata`, then moves to SETUP.
- SETUP: `psel=1`, `penable=0`. Always moves to ACCESS.
- ACCESS: `psel=1`, `penable=1`. Holds while `pready=0`.
  - `pready=1`, `pslverr=0`: moves to IDLE. On a read, `prdata` is loaded into `hrdata`.
  - `pready=1`, `pslverr=1`: moves to ERR1. `hrdata` is unchanged.
- ERR1: `hresp=1`, `hready_resp=0`. Moves to ERR2.
- ERR2: `hresp=1`, `hready_resp=1`. A new transfer may be sampled here, with the same rules as IDLE.
- `hready_resp` is 1 only in IDLE and ERR2. `hresp` is 1 only in ERR1 and ERR2.
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through the end of ACCESS.
- `pwdata` keeps its last value during reads.
- Sampling is ignored when `hready=0` (another slave is stretching the bus), or when `htrans` is IDLE or BUSY.
- Reset values of outputs:
  - `hready_resp=1`, `hresp=0`, `hrdata=0`.
  - `psel=0`, `penable=0`, `pwrite=0`, `paddr=0`, `pwdata=0`.
  - `pstrb=0`. The state is IDLE.
- Reset asserted mid-transfer: at the next edge the bridge returns to IDLE and drops `psel`/`penable`. The APB transfer is abandoned. No error is reported.

## Timing
- Cycle 0 is the AHB address phase, sampled at the edge ending cycle 0.
- Read with a zero-wait APB slave: SETUP in cycle 1, ACCESS in cycle 2, IDLE in cycle 3.
  - `hready_resp` is low in cycles 1–2 and high in cycle 3, with `hrdata` valid.
  - The data phase is 3 cycles.
- Write with a zero-wait APB slave: WDATA, SETUP, ACCESS, IDLE. The data phase is 4 cycles.
- Each APB wait state adds one cycle in ACCESS.
- Error: after the failing ACCESS cycle, ERR1 and ERR2 follow, one cycle each.
- A pipelined next address phase that coincides with the completion cycle (IDLE or ERR2) is accepted with no bubble.

## Configuration
- Macro: `AHBL_APB_PSTRB_EN`.
- Defined: the `pstrb` port exists and is registered at sampling.
  - Writes:
    - byte: `4'b0001 << haddr[1:0]`
    - half: `4'b0011 << {haddr[1],1'b0}`
    - word: `4'b1111`
  - Reads: `pstrb = 0`.
- Undefined: no `pstrb` port. The APB slave treats every write as a full word. The `hsize` error check remains active.

## Structure
- Shared package `ahbl_pkg`:
  - state enum `apb_br_state_t`
  - HTRANS constants (`HTRANS_IDLE`, `HTRANS_BUSY`, `HTRANS_NONSEQ`, `HTRANS_SEQ`)
  - HSIZE constants (`HSIZE_BYTE`, `HSIZE_HALF`, `HSIZE_WORD`)
- One sub-module: `ahbl_apb_strb_gen`, a combinational hsize/haddr-to-strobe decoder, instantiated only under the macro.
- Everything else is a single FSM with registered outputs.

## Test plan
- Read of 0x4000_0010 with `prdata`=0xDEADBEEF and `pready` held 1:
  - `paddr`=0x0010, with SETUP then ACCESS on consecutive cycles.
  - `hrdata`=0xDEADBEEF with `hready_resp`=1 in cycle 3.
- Word write of 0x1234_5678 to 0x4000_0004, with `pready` low for 2 ACCESS cycles:
  - `pwdata` stable from SETUP onward.
  - The data phase is 6 cycles.
  - `pstrb`=4'hF when the macro is enabled.
- Byte write to 0x4000_0003 with the macro enabled: `pstrb`=4'b1000. Half-word write to 0x...02: `pstrb`=4'b1100.
- Read with `pslverr`=1:
  - ERR1 (`hresp`=1, `hready_resp`=0), then ERR2 (`hresp`=1, `hready_resp`=1).
  - `hrdata` is unchanged.
- Write with `hsize`=3:
  - `psel` never asserts.
  - The two-cycle ERROR response starts in the cycle after the address phase.
- Back-to-back read then write, with the second address phase in the completion cycle:
  - The second transfer is accepted without an idle cycle.
- Reset for one cycle during ACCESS: `psel`, `penable` and `hresp` are 0 and `hready_resp` is 1 at the next edge.
